gameover_banner_ctrl: RTL and testbench

Controller for the 32x16, 12-bit game-over banner ROM in the VGA fishing-sim display path. When the game-over condition is asserted, it sequences the banner on screen: slide-in from above, blink while held, then wait for a restart request. Each cycle it turns the pixel scan position into ROM row/col addresses. It matches the ROM's one-cycle registered-address latency and returns a pixel-aligned banner colour with a valid flag to the pixel mux.

---
 rtl/gameover_pkg.sv | 23 ++
 rtl/gameover_banner_ctrl_if.sv | 29 ++
 rtl/gameover_addr_gen.sv | 40 ++++
 rtl/gameover_banner_ctrl.sv | 139 +++++++++++++
 tb/tb_gameover_banner_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/gameover_pkg.sv
// Shared types and ROM geometry for the game-over banner controller.
package gameover_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SLIDE = 2'd1,
    SHOW  = 2'd2
  } banner_state_e;

  localparam int ROM_W       = 32;
  localparam int ROM_H       = 16;
  localparam int ROM_COLOR_W = 12;
  localparam int ROM_ROW_W   = $clog2(ROM_H);
  localparam int ROM_COL_W   = $clog2(ROM_W);

  localparam logic [ROM_COLOR_W-1:0] DEFAULT_KEY_COLOR = 12'h0F0;

  // On-screen extent of a ROM dimension after texel magnification.
  function automatic int scaled(input int texels, input int scaleLog2);
    return texels << scaleLog2;
  endfunction

endpackage

// File: rtl/gameover_banner_ctrl_if.sv
// Scan-position, ROM and pixel-mux signals of the game-over banner controller.
interface gameover_banner_ctrl_if;
  import gameover_pkg::*;

  logic [9:0]             x;
  logic [9:0]             y;
  logic                   video_on;
  logic                   frame_tick;
  logic                   game_over;
  logic                   restart_btn;
  logic [ROM_ROW_W-1:0]   rom_row;
  logic [ROM_COL_W-1:0]   rom_col;
  logic [ROM_COLOR_W-1:0] rom_color;
  logic                   banner_on;
  logic [ROM_COLOR_W-1:0] banner_rgb;
  logic                   restart_ack;
  logic                   busy;

  modport master (
    output x, y, video_on, frame_tick, game_over, restart_btn, rom_color,
    input  rom_row, rom_col, banner_on, banner_rgb, restart_ack, busy
  );

  modport slave (
    input  x, y, video_on, frame_tick, game_over, restart_btn, rom_color,
    output rom_row, rom_col, banner_on, banner_rgb, restart_ack, busy
  );

endinterface

// File: rtl/gameover_addr_gen.sv
// Combinational banner hit test and ROM row/column address generation.
module gameover_addr_gen
  import gameover_pkg::*;
#(
  parameter int X0         = 192,
  parameter int SCALE_LOG2 = 3
) (
  input  logic                 enable_i,
  input  logic [9:0]           x_i,
  input  logic [9:0]           y_i,
  input  logic signed [10:0]   topY_i,
  output logic                 hit_o,
  output logic [ROM_ROW_W-1:0] romRow_o,
  output logic [ROM_COL_W-1:0] romCol_o
);

  localparam int BANNER_W = scaled(ROM_W, SCALE_LOG2);
  localparam int BANNER_H = scaled(ROM_H, SCALE_LOG2);

  logic [11:0]        xOff;
  logic signed [11:0] yOff;
  logic               xInside;
  logic               yInside;

  // Left of X0 wraps to a huge unsigned offset, so one compare covers both edges.
  always_comb begin
    xOff     = {2'b00, x_i} - 12'(X0);
    yOff     = $signed({2'b00, y_i}) - $signed({topY_i[10], topY_i});
    xInside  = xOff < 12'(BANNER_W);
    yInside  = !yOff[11] && (yOff < $signed(12'(BANNER_H)));
    hit_o    = enable_i && xInside && yInside;
    romRow_o = '0;
    romCol_o = '0;
    if (hit_o) begin
      romRow_o = yOff[SCALE_LOG2 +: ROM_ROW_W];
      romCol_o = xOff[SCALE_LOG2 +: ROM_COL_W];
    end
  end

endmodule

// File: rtl/gameover_banner_ctrl.sv
// Game-over banner sequencer: slide-in, blink while held, restart handshake,
// and ROM-latency-aligned pixel output for the VGA pixel mux.
module gameover_banner_ctrl
  import gameover_pkg::*;
#(
  parameter int                     X0              = 192,
  parameter int                     Y_TARGET        = 176,
  parameter int                     SCALE_LOG2      = 3,
  parameter int                     SLIDE_STEP      = 4,
  parameter int                     BLINK_FRAMES    = 30,
  parameter int                     MIN_SHOW_FRAMES = 60,
  parameter logic [ROM_COLOR_W-1:0] KEY_COLOR       = DEFAULT_KEY_COLOR
) (
  input logic                   clk,
  input logic                   reset,
  gameover_banner_ctrl_if.slave bus
);

  localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);
  localparam int SHOW_W  = $clog2(MIN_SHOW_FRAMES + 2);
  localparam logic signed [10:0] TOP_START  = 11'(-scaled(ROM_H, SCALE_LOG2));
  localparam logic signed [10:0] TOP_TARGET = 11'(Y_TARGET);
  localparam logic signed [10:0] STEP       = 11'(SLIDE_STEP);

  banner_state_e      state_q, state_d;
  logic signed [10:0] topY_q, topY_d;
  logic [BLINK_W-1:0] blinkCnt_q, blinkCnt_d;
  logic [SHOW_W-1:0]  showCnt_q, showCnt_d;
  logic               visible_q, visible_d;
  logic               restartAck_q, restartAck_d;
  logic               gameOverPrev_q;
  logic               hit_q;

  logic               busy;
  logic               hit;
  logic               rise;
  logic signed [10:0] slideNext;
  logic [ROM_ROW_W-1:0] romRow;
  logic [ROM_COL_W-1:0] romCol;

  assign busy      = (state_q != IDLE);
  assign rise      = bus.game_over && !gameOverPrev_q;
  assign slideNext = topY_q + STEP;

  gameover_addr_gen #(
    .X0         (X0),
    .SCALE_LOG2 (SCALE_LOG2)
  ) u_addr_gen (
    .enable_i (busy && visible_q && bus.video_on),
    .x_i      (bus.x),
    .y_i      (bus.y),
    .topY_i   (topY_q),
    .hit_o    (hit),
    .romRow_o (romRow),
    .romCol_o (romCol)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      topY_q         <= TOP_START;
      blinkCnt_q     <= '0;
      showCnt_q      <= '0;
      visible_q      <= 1'b1;
      restartAck_q   <= 1'b0;
      gameOverPrev_q <= 1'b0;
      hit_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      topY_q         <= topY_d;
      blinkCnt_q     <= blinkCnt_d;
      showCnt_q      <= showCnt_d;
      visible_q      <= visible_d;
      restartAck_q   <= restartAck_d;
      gameOverPrev_q <= bus.game_over;
      hit_q          <= hit;
    end
  end

  // Dropping game_over beats everything; an accepted restart beats a frame tick.
  always_comb begin
    state_d      = state_q;
    topY_d       = topY_q;
    blinkCnt_d   = blinkCnt_q;
    showCnt_d    = showCnt_q;
    visible_d    = visible_q;
    restartAck_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d   = SLIDE;
          topY_d    = TOP_START;
          visible_d = 1'b1;
        end
      end
      SLIDE: begin
        if (!bus.game_over) begin
          state_d = IDLE;
        end else if (bus.frame_tick) begin
          if (slideNext >= TOP_TARGET) begin
            topY_d     = TOP_TARGET;
            state_d    = SHOW;
            blinkCnt_d = '0;
            showCnt_d  = '0;
          end else begin
            topY_d = slideNext;
          end
        end
      end
      SHOW: begin
        if (!bus.game_over) begin
          state_d = IDLE;
        end else if (bus.restart_btn && (showCnt_q >= SHOW_W'(MIN_SHOW_FRAMES))) begin
          restartAck_d = 1'b1;
          state_d      = IDLE;
        end else if (bus.frame_tick) begin
          if (showCnt_q != '1) begin
            showCnt_d = showCnt_q + 1'b1;
          end
          if (blinkCnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
            blinkCnt_d = '0;
            visible_d  = !visible_q;
          end else begin
            blinkCnt_d = blinkCnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rom_row     = romRow;
  assign bus.rom_col     = romCol;
  assign bus.busy        = busy;
  assign bus.restart_ack = restartAck_q;
  assign bus.banner_on   = hit_q && (bus.rom_color != KEY_COLOR);
  assign bus.banner_rgb  = bus.banner_on ? bus.rom_color : '0;

endmodule

// File: tb/tb_gameover_banner_ctrl.sv
// Scoreboard bench for gameover_banner_ctrl: a frame-level reference model
// predicts addresses and pixel outputs, a negedge monitor compares them.
module tb_gameover_banner_ctrl;
  import gameover_pkg::*;

  localparam int          X0       = 192;
  localparam int          Y_TARGET = 176;
  localparam int          SCALE    = 3;
  localparam int          STEP     = 4;
  localparam int          BLINK    = 30;
  localparam int          MIN_SHOW = 60;
  localparam logic [11:0] KEY      = 12'h0F0;
  localparam int          BW       = 256;
  localparam int          BH       = 128;

  typedef struct {
    int         stamp;
    logic [3:0] row;
    logic [4:0] col;
  } addrExp_t;

  typedef struct {
    int          stamp;
    logic        busy;
    logic        ack;
    logic        on;
    logic [11:0] rgb;
  } outExp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  gameover_banner_ctrl_if bus();

  gameover_banner_ctrl #(
    .X0              (X0),
    .Y_TARGET        (Y_TARGET),
    .SCALE_LOG2      (SCALE),
    .SLIDE_STEP      (STEP),
    .BLINK_FRAMES    (BLINK),
    .MIN_SHOW_FRAMES (MIN_SHOW),
    .KEY_COLOR       (KEY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural banner ROM with a registered address.
  logic [11:0] romMem [0:511];
  always @(posedge clk) bus.rom_color <= romMem[{bus.rom_row, bus.rom_col}];

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int errors = 0;
  int checks = 0;
  addrExp_t addrQ[$];
  outExp_t  outQ[$];
  addrExp_t monA;
  outExp_t  monO;

  // Reference model: mode 0 idle, 1 sliding, 2 showing; counts whole frames.
  int mMode = 0;
  int mSlide = 0;
  int mShow = 0;
  bit mPrevGo = 0;
  bit goLevel = 0;

  function automatic int modelTop();
    return (mMode == 1) ? (-BH + STEP * mSlide) : Y_TARGET;
  endfunction

  function automatic bit modelVisible();
    return (mMode == 2) ? (((mShow / BLINK) % 2) == 0) : 1'b1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic modelStep(input bit go, input bit ft, input bit rb, output bit ack);
    bit rise;
    rise = go && !mPrevGo;
    mPrevGo = go;
    ack = 1'b0;
    case (mMode)
      0: if (rise) begin mMode = 1; mSlide = 0; end
      1: begin
        if (!go) mMode = 0;
        else if (ft) begin
          mSlide++;
          if (-BH + STEP * mSlide >= Y_TARGET) begin mMode = 2; mShow = 0; end
        end
      end
      default: begin
        if (!go) mMode = 0;
        else if (rb && mShow >= MIN_SHOW) begin ack = 1'b1; mMode = 0; end
        else if (ft) mShow++;
      end
    endcase
  endtask

  task automatic applyStimulus(input int px, input int py, input bit vo, input bit ft, input bit rb);
    int top, row, col;
    bit hit, on, ack;
    logic [11:0] colour;
    @(posedge clk);
    #1;
    bus.x           = px[9:0];
    bus.y           = py[9:0];
    bus.video_on    = vo;
    bus.frame_tick  = ft;
    bus.restart_btn = rb;
    bus.game_over   = goLevel;
    top = modelTop();
    hit = (mMode != 0) && modelVisible() && vo && px >= X0 && px < X0 + BW && py >= top && py < top + BH;
    row = hit ? (py - top) >> SCALE : 0;
    col = hit ? (px - X0) >> SCALE : 0;
    addrQ.push_back('{cycle, row[3:0], col[4:0]});
    colour = romMem[row * 32 + col];
    on = hit && (colour != KEY);
    modelStep(goLevel, ft, rb, ack);
    outQ.push_back('{cycle + 1, (mMode != 0), ack, on, on ? colour : 12'h000});
  endtask

  always @(negedge clk) begin
    if (addrQ.size() > 0 && addrQ[0].stamp == cycle) begin
      monA = addrQ.pop_front();
      checkOutput("rom_row", 32'(bus.rom_row), 32'(monA.row));
      checkOutput("rom_col", 32'(bus.rom_col), 32'(monA.col));
    end
    if (outQ.size() > 0 && outQ[0].stamp == cycle) begin
      monO = outQ.pop_front();
      checkOutput("busy", 32'(bus.busy), 32'(monO.busy));
      checkOutput("restart_ack", 32'(bus.restart_ack), 32'(monO.ack));
      checkOutput("banner_on", 32'(bus.banner_on), 32'(monO.on));
      checkOutput("banner_rgb", 32'(bus.banner_rgb), 32'(monO.rgb));
    end
  end

  task automatic applyReset();
    #1;
    reset = 1'b1;
    goLevel = 1'b0;
    bus.x = '0; bus.y = '0; bus.video_on = 1'b0;
    bus.frame_tick = 1'b0; bus.restart_btn = 1'b0; bus.game_over = 1'b0;
    addrQ.delete();
    outQ.delete();
    mMode = 0; mSlide = 0; mShow = 0; mPrevGo = 1'b0;
    #1;
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset banner_on", 32'(bus.banner_on), 32'd0);
    checkOutput("reset banner_rgb", 32'(bus.banner_rgb), 32'd0);
    checkOutput("reset restart_ack", 32'(bus.restart_ack), 32'd0);
    checkOutput("reset rom_row", 32'(bus.rom_row), 32'd0);
    checkOutput("reset rom_col", 32'(bus.rom_col), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic pixel(input int px, input int py, input bit rb);
    if (py >= 0 && py <= 1023 && px >= 0 && px <= 1023) applyStimulus(px, py, 1'b1, 1'b0, rb);
  endtask

  // One frame: banner-edge probes, random pixels near the banner, then a blanking tick.
  task automatic runFrame(input int nPix, input bit rbMid, input bit rbTick);
    int top, lo, hi;
    top = modelTop();
    pixel(X0, top - 1, 1'b0);
    pixel(X0, top, 1'b0);
    pixel(X0 - 1, top, 1'b0);
    pixel(X0 + BW - 1, top + BH - 1, 1'b0);
    pixel(X0 + BW, top, 1'b0);
    pixel(X0 + 8, top + 40, 1'b0);
    pixel(X0 + BW, top + 40, 1'b0);
    lo = (top - 10 < 0) ? 0 : top - 10;
    hi = top + BH + 10;
    if (hi < lo + 20) hi = lo + 20;
    for (int i = 0; i < nPix; i++) begin
      applyStimulus(int'($urandom_range(X0 + BW + 20, X0 - 20)), int'($urandom_range(hi, lo)),
                    ($urandom_range(7, 0) != 0), 1'b0, 1'b0);
    end
    if (rbMid) pixel(X0 + 16, top + 16, 1'b1);
    applyStimulus(0, 500, 1'b0, 1'b1, rbTick);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      romMem[i] = ($urandom_range(3, 0) == 0) ? KEY : 12'($urandom);
    end
    romMem[0]      = KEY;
    romMem[5 * 32 + 1] = 12'h000;

    @(posedge clk);
    applyReset();

    // Restart pulses while idle are ignored.
    runFrame(2, 1'b1, 1'b1);

    goLevel = 1'b1;
    for (int f = 0; f < 76; f++) runFrame(4, 1'b0, 1'b0);

    for (int f = 0; f < 10; f++) runFrame(4, 1'b0, 1'b0);
    runFrame(4, 1'b1, 1'b0);
    while (mShow < MIN_SHOW) runFrame(4, 1'b0, 1'b0);
    runFrame(4, 1'b0, 1'b1);
    repeat (3) applyStimulus(X0, Y_TARGET, 1'b1, 1'b0, 1'b0);

    goLevel = 1'b0;
    applyStimulus(0, 0, 1'b0, 1'b0, 1'b0);
    goLevel = 1'b1;
    for (int f = 0; f < 20; f++) runFrame(3, 1'b1, 1'b0);
    applyReset();

    goLevel = 1'b1;
    for (int f = 0; f < 81; f++) runFrame(3, 1'b0, 1'b0);
    goLevel = 1'b0;
    repeat (3) applyStimulus(X0 + 8, Y_TARGET + 40, 1'b1, 1'b0, 1'b1);
    runFrame(2, 1'b1, 1'b1);

    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("addr queue drained", 32'(addrQ.size()), 32'd0);
    checkOutput("out queue drained", 32'(outQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
